// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding
// and the default operand width.
package mult_pkg;

    localparam int MULT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Operand/product valid-ready bundle for seq_mult_ctrl.
// The master drives operands and accepts products; the slave is the multiplier.
interface seq_mult_ctrl_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/seq_mult_ctrl_rca.sv
// Ripple-carry adder (rca_Nbit) built from a chain of full_addr cells;
// the multiplier reuses one instance for every iteration.
module full_addr (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_Nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_addr u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[N];
endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add unsigned multiplier sharing one N-bit adder over N cycles.
// SEQ_MULT_ZERO_BYPASS_EN: zero operands skip RUN and go straight to DONE.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int N = MULT_W
) (
    input  logic            clk,
    input  logic            rst,
    seq_mult_ctrl_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    state_t           state, state_nx;
    logic [N-1:0]     mcand, mcand_nx;
    logic [2*N-1:0]   acc, acc_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [N-1:0]     add_b;
    logic [N-1:0]     sum;
    logic             cout;
    logic             zero_op;

    assign add_b = acc[0] ? mcand : '0;

    rca_Nbit #(.N(N)) u_rca (
        .a    (acc[2*N-1:N]),
        .b    (add_b),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

`ifdef SEQ_MULT_ZERO_BYPASS_EN
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            mcand <= mcand_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mcand_nx = mcand;
        acc_nx   = acc;
        cnt_nx   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mcand_nx = bus.a;
                    cnt_nx   = CW'(N);
                    if (zero_op) begin
                        acc_nx   = '0;
                        state_nx = ST_DONE;
                    end else begin
                        acc_nx   = {{N{1'b0}}, bus.b};
                        state_nx = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // keep the adder carry so the top product bit is never lost
                acc_nx = {cout, sum, acc[N-1:1]};
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.p         = acc;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and randomised checks of seq_mult_ctrl at N=8 and N=16.
// Honours SEQ_MULT_ZERO_BYPASS_EN for the zero-operand latency.
module tb_seq_mult_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl_if #(.N(8))  m8 ();
    seq_mult_ctrl_if #(.N(16)) m16 ();

    seq_mult_ctrl #(.N(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (m8.slave)
    );

    seq_mult_ctrl #(.N(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (m16.slave)
    );

    // cycles from the acceptance edge to the edge that raises out_valid
`ifdef SEQ_MULT_ZERO_BYPASS_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 8;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mul_op(input logic [7:0] ta, input logic [7:0] tb_,
                          input int hold, input bit noisy,
                          output int lat, output logic [15:0] prod);
        int n = 0;
        @(negedge clk);
        m8.out_ready = 1'b0;
        m8.in_valid  = 1'b1;
        m8.a         = ta;
        m8.b         = tb_;
        while (!m8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(m8.in_ready), 1);
        @(posedge clk);
        #1;
        m8.in_valid = noisy;
        lat = 0;
        while (!m8.out_valid && lat < 50) begin
            if (noisy) begin
                m8.a         = 8'($urandom);
                m8.b         = 8'($urandom);
                m8.out_ready = 1'b1;
                check("busy_rdy", 32'(m8.in_ready), 0);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        m8.in_valid = 1'b0;
        prod = m8.p;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_v", 32'(m8.out_valid), 1);
            check("hold_p", 32'(m8.p), 32'(prod));
        end
        m8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        m8.out_ready = 1'b0;
        check("post_v", 32'(m8.out_valid), 0);
        check("post_rdy", 32'(m8.in_ready), 1);
    endtask

    task automatic rand8(input int total);
        logic [15:0] q[$];
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit taken = 1'b0;
        while (got < total && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (taken) m8.in_valid = 1'b0;
            taken = 1'b0;
            if (!m8.in_valid && sent < total && $urandom_range(0, 3) != 0) begin
                m8.in_valid = 1'b1;
                m8.a = 8'($urandom);
                m8.b = 8'($urandom);
            end
            m8.out_ready = 1'($urandom_range(0, 1));
            if (m8.in_valid && m8.in_ready) begin
                q.push_back({8'b0, m8.a} * {8'b0, m8.b});
                sent++;
                taken = 1'b1;
            end
            if (m8.out_valid && m8.out_ready) begin
                check("r8_sb", 32'(q.size() != 0), 1);
                if (q.size() != 0) check("r8_p", 32'(m8.p), 32'(q.pop_front()));
                got++;
            end
        end
        @(negedge clk);
        m8.in_valid  = 1'b0;
        m8.out_ready = 1'b0;
        check("r8_count", got, total);
        check("r8_left", q.size(), 0);
    endtask

    task automatic rand16(input int total);
        logic [31:0] q[$];
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit taken = 1'b0;
        while (got < total && cyc < 45000) begin
            @(negedge clk);
            cyc++;
            if (taken) m16.in_valid = 1'b0;
            taken = 1'b0;
            if (!m16.in_valid && sent < total && $urandom_range(0, 3) != 0) begin
                m16.in_valid = 1'b1;
                m16.a = 16'($urandom);
                m16.b = 16'($urandom);
            end
            m16.out_ready = 1'($urandom_range(0, 1));
            if (m16.in_valid && m16.in_ready) begin
                q.push_back({16'b0, m16.a} * {16'b0, m16.b});
                sent++;
                taken = 1'b1;
            end
            if (m16.out_valid && m16.out_ready) begin
                check("r16_sb", 32'(q.size() != 0), 1);
                if (q.size() != 0) check("r16_p", m16.p, q.pop_front());
                got++;
            end
        end
        @(negedge clk);
        m16.in_valid  = 1'b0;
        m16.out_ready = 1'b0;
        check("r16_count", got, total);
        check("r16_left", q.size(), 0);
    endtask

    initial begin
        int          lat;
        logic [15:0] prod;
        bit          seen;
        rst = 1'b1;
        m8.in_valid   = 1'b0;
        m8.a          = '0;
        m8.b          = '0;
        m8.out_ready  = 1'b0;
        m16.in_valid  = 1'b0;
        m16.a         = '0;
        m16.b         = '0;
        m16.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 32'(m8.in_ready), 1);
        check("rst_v", 32'(m8.out_valid), 0);
        check("rst_p", 32'(m8.p), 0);
        rst = 1'b0;

        mul_op(8'd13, 8'd11, 0, 1'b0, lat, prod);
        check("lat_13x11", lat, 8);
        check("p_13x11", 32'(prod), 143);

        mul_op(8'd255, 8'd255, 0, 1'b0, lat, prod);
        check("p_255x255", 32'(prod), 32'h0000_FE01);

        mul_op(8'd200, 8'd3, 5, 1'b0, lat, prod);
        check("p_200x3", 32'(prod), 600);

        mul_op(8'd5, 8'd6, 0, 1'b1, lat, prod);
        check("lat_busy", lat, 8);
        check("p_busy", 32'(prod), 30);

        mul_op(8'd0, 8'd77, 0, 1'b0, lat, prod);
        check("lat_0x77", lat, ZLAT);
        check("p_0x77", 32'(prod), 0);

        mul_op(8'd77, 8'd0, 0, 1'b0, lat, prod);
        check("lat_77x0", lat, ZLAT);
        check("p_77x0", 32'(prod), 0);

        // reset lands on the fourth RUN iteration of 100*100
        @(negedge clk);
        m8.in_valid = 1'b1;
        m8.a        = 8'd100;
        m8.b        = 8'd100;
        @(posedge clk);
        #1;
        m8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_rdy", 32'(m8.in_ready), 1);
        check("mid_rst_v", 32'(m8.out_valid), 0);
        check("mid_rst_p", 32'(m8.p), 0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen |= m8.out_valid;
        end
        check("mid_rst_quiet", 32'(seen), 0);

        mul_op(8'd7, 8'd9, 0, 1'b0, lat, prod);
        check("p_7x9", 32'(prod), 63);

        rand8(1000);
        rand16(1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
